// File: rtl/onchip_memory_pipelined.sv
// Single-port Avalon-MM on-chip RAM with byte lanes, a 1- or 2-cycle read pipeline,
// waitrequest flow control and an optional zero-fill pass after reset.
module onchip_memory_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clear_cnt;
  logic                    en;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    clear_wr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   ram_q;
  logic                    s1_valid;
  logic                    out_valid;

  // Handshake: a command is taken on a rising edge where chipselect and read/write
  // are high and waitrequest is low; write wins over a simultaneous read, and the
  // read then produces no readdatavalid.
  assign en          = clken & ~reset_req;
  assign waitrequest = (state == ST_CLEAR) | ~en;
  assign wr_acc      = chipselect & write & ~waitrequest;
  assign rd_acc      = chipselect & read & ~write & ~waitrequest;
  assign clear_wr    = (state == ST_CLEAR) & en & ~reset;

  // Clear sequencer; terminal compare on the last word avoids needing a wider counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clear_cnt <= '0;
    end else if (en && state == ST_CLEAR) begin
      clear_cnt <= clear_cnt + 1'b1;
      if (clear_cnt == '1) begin
        state <= ST_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear_wr) begin
      mem[clear_cnt] <= '0;
    end else if (wr_acc && !reset) begin
      for (int i = 0; i < BYTES; i++) begin
        if (byteenable[i]) begin
          mem[address][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  // Synchronous array read; ram_q only changes on an accepted read, so it also
  // serves as the held readdata for the single-cycle latency build.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_q <= '0;
    end else if (rd_acc) begin
      ram_q <= mem[address];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= rd_acc;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_rl2
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else if (en) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= ram_q;
          end
        end
      end

      assign readdata  = s2_data;
      assign out_valid = s2_valid;
    end else begin : g_rl1
      assign readdata  = ram_q;
      assign out_valid = s1_valid;
    end
  endgenerate

  // A frozen pipeline keeps its valid bit; it is delivered once en returns.
  assign readdatavalid = out_valid & en;

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Directed bench: three instances share stimulus (latency 1 / latency 2 / no clear)
// and every readdatavalid pulse is matched against an expected queue of data and cycle.
module tb_onchip_memory_pipelined;

  typedef struct packed {
    logic        care;
    logic [31:0] cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        reset_req;

  logic [31:0] rd [3];
  logic        rdv [3];
  logic        wr [3];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;
  exp_t exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  onchip_memory_pipelined #(.READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_rl1 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req),
    .readdata(rd[0]), .readdatavalid(rdv[0]), .waitrequest(wr[0])
  );

  onchip_memory_pipelined #(.READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_rl2 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req),
    .readdata(rd[1]), .readdatavalid(rdv[1]), .waitrequest(wr[1])
  );

  onchip_memory_pipelined #(.READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut_noclr (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req),
    .readdata(rd[2]), .readdatavalid(rdv[2]), .waitrequest(wr[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: each pulse must match the head of its instance's queue.
  task automatic mon_one(input int idx);
    exp_t e;
    if (rdv[idx]) begin
      if (exp_q[idx].size() == 0) begin
        check($sformatf("dut%0d_unexpected_rdv", idx), 32'd1, 32'd0);
      end else begin
        e = exp_q[idx].pop_front();
        check($sformatf("dut%0d_rdv_cycle", idx), cyc, e.cyc);
        if (e.care) check($sformatf("dut%0d_readdata", idx), rd[idx], e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_one(0);
      mon_one(1);
      mon_one(2);
    end
  end

  task automatic set_idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'h0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    set_idle();
    step(n);
  endtask

  // dly_a applies to the two latency-1 instances, dly_b to the latency-2 one (<0: never delivered).
  task automatic issue_read(input logic [7:0] addr, input logic [31:0] exp_c,
                            input logic [31:0] exp_u, input bit care_u,
                            input int dly_a, input int dly_b);
    exp_t e;
    e.care = 1'b1; e.data = exp_c; e.cyc = cyc + 1 + dly_a;
    exp_q[0].push_back(e);
    if (dly_b >= 0) begin
      e.cyc = cyc + 2 + dly_b;
      exp_q[1].push_back(e);
    end
    e.care = care_u; e.data = exp_u; e.cyc = cyc + 1 + dly_a;
    exp_q[2].push_back(e);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = addr;
    step(1);
    set_idle();
  endtask

  task automatic write_word(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    chipselect = 1'b1; read = 1'b0; write = 1'b1;
    address = addr; writedata = data; byteenable = be;
    step(1);
    set_idle();
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 3; k++) check($sformatf("%s_pending%0d", tag, k), exp_q[k].size(), 32'd0);
  endtask

  // Counts waitrequest-high cycles per instance after reset release; also checks reset outputs.
  task automatic count_wait(input string tag, input int exp_a, input int exp_b, input int exp_c);
    int  cnt [3];
    bit  done [3];
    for (int k = 0; k < 3; k++) begin
      cnt[k]  = 0;
      done[k] = 1'b0;
    end
    for (int i = 0; i < 600 && !(done[0] && done[1] && done[2]); i++) begin
      @(negedge clk);
      #1;
      if (i == 0) begin
        for (int k = 0; k < 3; k++) begin
          check($sformatf("%s_rst_readdata%0d", tag, k), rd[k], 32'h0);
          check($sformatf("%s_rst_rdv%0d", tag, k), {31'b0, rdv[k]}, 32'h0);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (!done[k]) begin
          if (wr[k]) cnt[k]++;
          else done[k] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_wait_rl1"}, cnt[0], exp_a);
    check({tag, "_wait_rl2"}, cnt[1], exp_b);
    check({tag, "_wait_noclr"}, cnt[2], exp_c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    address = 8'h0; writedata = 32'h0;
    set_idle();
    step(2);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Zero-fill after reset; the no-clear instance is ready immediately.
    count_wait("t1", 256, 256, 0);
    issue_read(8'h00, 32'h0, 32'h0, 1'b0, 0, 0);
    issue_read(8'h7F, 32'h0, 32'h0, 1'b0, 0, 0);
    issue_read(8'hFF, 32'h0, 32'h0, 1'b0, 0, 0);
    idle(4);
    drain("t1");

    // Byte-lane merge.
    write_word(8'h05, 32'hAABBCCDD, 4'hF);
    write_word(8'h05, 32'h11223344, 4'h5);
    issue_read(8'h05, 32'hAA22CC44, 32'hAA22CC44, 1'b1, 0, 0);
    idle(4);
    drain("t2");

    // Back-to-back reads at full throughput.
    write_word(8'h01, 32'h10, 4'hF);
    write_word(8'h02, 32'h20, 4'hF);
    write_word(8'h03, 32'h30, 4'hF);
    write_word(8'h04, 32'h40, 4'hF);
    issue_read(8'h01, 32'h10, 32'h10, 1'b1, 0, 0);
    issue_read(8'h02, 32'h20, 32'h20, 1'b1, 0, 0);
    issue_read(8'h03, 32'h30, 32'h30, 1'b1, 0, 0);
    issue_read(8'h04, 32'h40, 32'h40, 1'b1, 0, 0);
    idle(5);
    drain("t3");

    // Freeze with two reads in flight and a write held on the bus.
    issue_read(8'h01, 32'h10, 32'h10, 1'b1, 0, 3);
    issue_read(8'h02, 32'h20, 32'h20, 1'b1, 3, 3);
    reset_req = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 8'h01;
    writedata = 32'hFFFFFFFF; byteenable = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("t4_freeze_wait%0d", k), {31'b0, wr[k]}, 32'd1);
        check($sformatf("t4_freeze_rdv%0d", k), {31'b0, rdv[k]}, 32'd0);
      end
      @(posedge clk);
      #1;
    end
    reset_req = 1'b0;
    idle(6);
    drain("t4");
    issue_read(8'h01, 32'h10, 32'h10, 1'b1, 0, 0);
    idle(4);
    drain("t4_nowrite");

    // Simultaneous read and write: write lands, read is dropped.
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 8'h09; writedata = 32'hDEADBEEF; byteenable = 4'hF;
    step(1);
    idle(4);
    drain("t5_drop");
    issue_read(8'h09, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 0, 0);
    idle(4);
    drain("t5");

    // Reset with a read in flight (the latency-2 copy must never deliver it).
    issue_read(8'h05, 32'hAA22CC44, 32'hAA22CC44, 1'b1, 0, -1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    idle(100);
    // Reset again with the clear counter at 100: the fill starts over.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    count_wait("t6", 256, 256, 0);
    drain("t6_inflight");
    issue_read(8'h05, 32'h0, 32'hAA22CC44, 1'b1, 0, 0);
    issue_read(8'h09, 32'h0, 32'hDEADBEEF, 1'b1, 0, 0);
    issue_read(8'h01, 32'h0, 32'h10, 1'b1, 0, 0);
    idle(4);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onchip_memory_pipelined.md
Name: onchip_memory_pipelined

Overview:
Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It extends the fixed 4×32 unregistered RAM in four ways:
- configurable width, depth and read latency;
- a readdatavalid read pipeline;
- waitrequest flow control;
- a post-reset zero-fill sequencer.

It sits on the system interconnect as a scratch or shared buffer for the CPU and for game-logic masters.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8; BYTES = DATA_WIDTH/8.
ADDR_WIDTH, 8, word-address width; DEPTH = 2**ADDR_WIDTH words.
READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 or 2 (2 adds an output register).
CLEAR_ON_RESET, 1, when 1, zero-fill all words after reset before accepting commands; when 0, contents are untouched.

Ports:
clk  in  1  system clock; everything is synchronous to its rising edge.
reset  in  1  synchronous, active-high reset.
address  in  ADDR_WIDTH  word address.
byteenable  in  BYTES  write byte-lane enables.
chipselect  in  1  slave select.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
clken  in  1  clock enable.
reset_req  in  1  reset-request freeze; while high, all sequential state holds.
readdata  out  DATA_WIDTH  read data.
readdatavalid  out  1  one-cycle pulse per completed read.
waitrequest  out  1  slave not accepting commands this cycle.

Behaviour:
- Clock enable: en = clken & ~reset_req. When en=0:
  - no RAM write occurs;
  - the clear counter, FSM and read pipeline all hold;
  - readdatavalid=0.
- waitrequest = (state==CLEAR) | ~en. This is combinational from the state and inputs.
- Accept conditions:
  - write accepted: chipselect & write & ~waitrequest.
  - read accepted: chipselect & read & ~write & ~waitrequest.
  - read and write asserted together: the write is performed, the read is dropped and produces no readdatavalid.
- Reset (reset=1 at an edge):
  - state = CLEAR if CLEAR_ON_RESET else READY;
  - clear counter = 0;
  - read pipeline valid bits = 0;
  - readdata = 0, readdatavalid = 0;
  - in-flight reads are discarded, never delivered.
  - Reset overrides en.
  - Reset asserted mid-clear restarts the clear from address 0.
- FSM CLEAR:
  - each en cycle writes 0 to all lanes of word[clear_cnt], then clear_cnt increments;
  - after word DEPTH-1 is written, the FSM enters READY on the same edge;
  - with en held high, waitrequest is 1 for exactly DEPTH cycles after reset deasserts.
- FSM READY: stays in READY until reset. The counter does not run.
- Write: lanes with byteenable[i]=1 update bits [8i+7:8i] at the accept edge. Other lanes keep their value. byteenable=0 is a legal no-op.
- Read timing:
  - array read is synchronous, sampled at the accept edge T;
  - READ_LATENCY=1: readdata/readdatavalid are valid in cycle T+1;
  - READ_LATENCY=2: valid in cycle T+2, through an extra register stage.
  - Back-to-back reads are accepted every cycle, so full throughput is one word per cycle and data returns in issue order.
- readdata holds its last delivered value when readdatavalid=0.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. Same-cycle read/write collision cannot occur because write wins.
- Stall: en low for N cycles while reads are in flight delays their delivery by exactly N cycles. Order is preserved and no read is lost or duplicated.
- Address width exactly spans DEPTH, so there is no out-of-range case. clear_cnt is ADDR_WIDTH+1 bits, or a terminal compare, to avoid a wrap-around hazard.

Test Plan:
1. Reset clear (defaults, CLEAR_ON_RESET=1):
   - Stimulus: reset 2 cycles, then release with en=1.
   - Required: waitrequest=1 for exactly 256 cycles, then 0.
   - Required: reads of addresses 0, 0x7F and 0xFF return 0x00000000.
2. Byte-lane write:
   - Stimulus: write 0xAABBCCDD with byteenable 0xF to addr 5; then 0x11223344 with byteenable 0x5 to addr 5; then read addr 5.
   - Required: readdata 0xAA22CC44 with readdatavalid exactly 1 cycle after the read accept.
3. Pipelined reads, READ_LATENCY=2:
   - Stimulus: pre-load addrs 1..4 = 0x10..0x40; issue 4 consecutive reads.
   - Required: readdatavalid high for 4 consecutive cycles starting at accept+2, carrying 0x10, 0x20, 0x30, 0x40 in order.
4. Freeze:
   - Stimulus: 2 reads in flight, then reset_req=1 for 3 cycles.
   - Required: waitrequest=1 and readdatavalid=0 during the freeze; both reads delivered 3 cycles late, in order; no RAM write during the freeze even with write=1.
5. Simultaneous read and write:
   - Stimulus: read=write=1 to addr 9 with data 0xDEADBEEF.
   - Required: no readdatavalid pulse; a following read of addr 9 returns 0xDEADBEEF.
6. Reset mid-operation:
   - Stimulus: assert reset at clear_cnt=100, and separately with a read in flight.
   - Required: clear restarts and waitrequest stays high for a full 256 cycles; the in-flight read never asserts readdatavalid.
   - Stimulus: repeat case 1 with CLEAR_ON_RESET=0.
   - Required: waitrequest=0 the first cycle after reset and prior contents are retained.
